// File: rtl/chip8_timer_pkg.sv
// Shared types and helpers for the Chip-8 delay/sound timer block.
package chip8_timer_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic {SEL_DELAY = 1'b0, SEL_SOUND = 1'b1} timer_sel_e;

  typedef enum logic [1:0] {S_IDLE, S_DEC_D, S_DEC_S} tseq_state_e;

  // Decrement that sticks at zero; a timer never wraps to all-ones.
  function automatic logic [TIMER_W-1:0] sat_dec(input logic [TIMER_W-1:0] v);
    return (v == '0) ? v : v - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/chip8_tick_gen.sv
// 60 Hz tick divider. Counts 0..DIV-1 and freezes while paused.
module chip8_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Strobe on the last count of an unpaused period.
  assign tick = (cnt == LAST) && !pause;

  // Divider: wraps on tick, holds while paused.
  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (!pause) cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/chip8_timer_ctrl.sv
// Chip-8 delay/sound timers: tick generation, CPU/host write arbitration
// and a three-state sequencer sharing one saturating decrementer.
module chip8_timer_ctrl
  import chip8_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_we,
  input  logic               cpu_sel,
  input  logic [TIMER_W-1:0] cpu_wdata,
  input  logic               host_we,
  input  logic               host_sel,
  input  logic [TIMER_W-1:0] host_wdata,
  output logic               host_ack,
  input  logic               pause,
  output logic [TIMER_W-1:0] delay_value,
  output logic [TIMER_W-1:0] sound_value,
  output logic               sound_on,
  output logic               tick_out
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  // The sequencer needs three cycles per tick; a shorter period would
  // let a tick land while it is still busy.
  if (DIV < 4) begin : g_div_chk
    $error("chip8_timer_ctrl: DIV must be >= 4");
  end

  logic               tick;
  tseq_state_e        state, state_n;
  logic               cpu_d_we, cpu_s_we;
  logic               host_blk, host_go, host_d_we, host_s_we;
  logic [TIMER_W-1:0] dec_in, dec_out;

  chip8_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .tick  (tick)
  );

  // CPU always wins a same-target collision; the host simply stays pending.
  // The ack cycle itself is ignored so a still-held request is not applied twice.
  assign cpu_d_we  = cpu_we && (cpu_sel == SEL_DELAY);
  assign cpu_s_we  = cpu_we && (cpu_sel == SEL_SOUND);
  assign host_blk  = cpu_we && (cpu_sel == host_sel);
  assign host_go   = host_we && !host_ack && !host_blk;
  assign host_d_we = host_go && (host_sel == SEL_DELAY);
  assign host_s_we = host_go && (host_sel == SEL_SOUND);

  // One decrementer, operand picked by sequencer state.
  assign dec_in  = (state == S_DEC_S) ? sound_value : delay_value;
  assign dec_out = sat_dec(dec_in);

  assign sound_on = (sound_value != '0);

  // Sequencer next state: IDLE -> DEC_D -> DEC_S -> IDLE per tick.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (tick) state_n = S_DEC_D;
      S_DEC_D: state_n = S_DEC_S;
      S_DEC_S: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Timer registers, sequencer state, ack and tick pulse; writes beat decrements.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      delay_value <= '0;
      sound_value <= '0;
      host_ack    <= 1'b0;
      tick_out    <= 1'b0;
    end else begin
      state    <= state_n;
      host_ack <= host_go;
      tick_out <= tick;

      if (cpu_d_we)              delay_value <= cpu_wdata;
      else if (host_d_we)        delay_value <= host_wdata;
      else if (state == S_DEC_D) delay_value <= dec_out;

      if (cpu_s_we)              sound_value <= cpu_wdata;
      else if (host_s_we)        sound_value <= host_wdata;
      else if (state == S_DEC_S) sound_value <= dec_out;
    end
  end

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// Directed bench for chip8_timer_ctrl with DIV = 4.
module tb_chip8_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset, cpu_we, cpu_sel, host_we, host_sel, pause;
  logic [7:0] cpu_wdata, host_wdata;
  logic       host_ack, sound_on, tick_out;
  logic [7:0] delay_value, sound_value;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  chip8_timer_ctrl #(.CLK_HZ(240), .TICK_HZ(60)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_we      (cpu_we),
    .cpu_sel     (cpu_sel),
    .cpu_wdata   (cpu_wdata),
    .host_we     (host_we),
    .host_sel    (host_sel),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .pause       (pause),
    .delay_value (delay_value),
    .sound_value (sound_value),
    .sound_on    (sound_on),
    .tick_out    (tick_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, cw, cs;
    logic [7:0] cd;
    logic       hw, hs;
    logic [7:0] hd;
    logic       ps;
    logic [7:0] ed, es;
    logic       et, ea;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, cw, cs, input logic [7:0] cd,
                     input logic hw, hs, input logic [7:0] hd, input logic ps,
                     input logic [7:0] ed, es, input logic et, ea);
    vec_t v;
    v.rst = rst; v.cw = cw; v.cs = cs; v.cd = cd;
    v.hw = hw; v.hs = hs; v.hd = hd; v.ps = ps;
    v.ed = ed; v.es = es; v.et = et; v.ea = ea;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; cpu_we = 1'b0; cpu_sel = 1'b0; cpu_wdata = 8'h00;
    host_we = 1'b0; host_sel = 1'b0; host_wdata = 8'h00; pause = 1'b0;
  endtask

  // Steps until tick_out is seen; returns the edge count, or -1 on timeout.
  task automatic wait_tick(input string name, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_out) begin
        at = edges;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no tick_out within 20 cycles", name);
    end
  endtask

  initial begin
    int t0, t1, ticks_seen;

    idle_inputs();
    reset = 1'b1;

    //   rst cw cs cd     hw hs hd     ps  delay  sound  tick ack
    // Reset, then countdown delay 3 / sound 2.
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    add(0, 1, 0, 8'h03, 0, 0, 8'h00, 0, 8'h03, 8'h00, 0, 0);
    add(0, 1, 1, 8'h02, 0, 0, 8'h00, 0, 8'h03, 8'h02, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h03, 8'h02, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h03, 8'h02, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h02, 8'h02, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h02, 8'h01, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h02, 8'h01, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h02, 8'h01, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h01, 8'h01, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    // Different targets: CPU delay=5, host sound=7; host holds through ack.
    add(0, 1, 0, 8'h05, 1, 1, 8'h07, 0, 8'h05, 8'h07, 0, 1);
    add(0, 0, 0, 8'h00, 1, 1, 8'h07, 0, 8'h05, 8'h07, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h05, 8'h07, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h04, 8'h07, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h04, 8'h06, 0, 0);
    // Same-target collision: CPU 0x10 wins, host 0x20 lands a cycle later.
    add(0, 1, 0, 8'h10, 1, 0, 8'h20, 0, 8'h10, 8'h06, 0, 0);
    add(0, 0, 0, 8'h00, 1, 0, 8'h20, 0, 8'h20, 8'h06, 1, 1);
    // Host still held in the ack cycle: must not re-apply, decrement proceeds.
    add(0, 0, 0, 8'h00, 1, 0, 8'h20, 0, 8'h1f, 8'h06, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h1f, 8'h05, 0, 0);
    // Write vs decrement: delay=9, then CPU writes 0x40 in the DEC_D cycle.
    add(0, 1, 0, 8'h09, 0, 0, 8'h00, 0, 8'h09, 8'h05, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h09, 8'h05, 1, 0);
    add(0, 1, 0, 8'h40, 0, 0, 8'h00, 0, 8'h40, 8'h05, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h40, 8'h04, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; cpu_we = vt[i].cw; cpu_sel = vt[i].cs; cpu_wdata = vt[i].cd;
      host_we = vt[i].hw; host_sel = vt[i].hs; host_wdata = vt[i].hd; pause = vt[i].ps;
      step();
      check($sformatf("vec%0d {delay,sound,on,tick,ack}", i),
            {13'd0, delay_value, sound_value, sound_on, tick_out, host_ack},
            {13'd0, vt[i].ed, vt[i].es, (vt[i].es != 8'h00), vt[i].et, vt[i].ea});
    end
    idle_inputs();

    // Pause for 10 cycles mid-period; a write during pause still lands.
    wait_tick("pause_sync", t0);
    step();
    step();
    check("pre_pause_delay", {24'd0, delay_value}, 32'h3f);
    check("pre_pause_sound", {24'd0, sound_value}, 32'h03);
    ticks_seen = 0;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cpu_we = 1'b1; cpu_sel = 1'b1; cpu_wdata = 8'h33;
      end else begin
        cpu_we = 1'b0;
      end
      step();
      if (tick_out) ticks_seen++;
    end
    check("pause_no_tick", ticks_seen, 0);
    check("pause_delay_held", {24'd0, delay_value}, 32'h3f);
    check("pause_write_applied", {24'd0, sound_value}, 32'h33);
    idle_inputs();
    wait_tick("pause_resume", t1);
    if (t0 >= 0 && t1 >= 0) check("tick_spacing", t1 - t0, 14);

    // Reset in the DEC_D cycle with a host request pending.
    cpu_we = 1'b1; cpu_sel = 1'b0; cpu_wdata = 8'h03;
    step();
    cpu_sel = 1'b1;
    step();
    idle_inputs();
    wait_tick("reset_sync", t0);
    check("pre_reset_delay", {24'd0, delay_value}, 32'h03);
    check("pre_reset_sound", {24'd0, sound_value}, 32'h03);
    reset = 1'b1; host_we = 1'b1; host_sel = 1'b1; host_wdata = 8'h55;
    step();
    check("reset_outputs {delay,sound,on,tick,ack}",
          {13'd0, delay_value, sound_value, sound_on, tick_out, host_ack}, 32'h0);
    host_we = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("post_reset_c%0d {delay,sound,tick,ack}", i),
            {14'd0, delay_value, sound_value, tick_out, host_ack},
            {14'd0, 8'h00, 8'h00, (i == 4), 1'b0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_timer_ctrl.md
# chip8_timer_ctrl

Owns the Chip-8 delay and sound timer registers and schedules every update to them. Generates the 60 Hz tick from the system clock and arbitrates writes from the CPU core and the Avalon/host side. Sequences the per-tick countdown through one shared 8-bit decrementer and drives the sound-enable line. Sits between the Chip8 CPU datapath and the qsys-facing register block.

## Interface
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 60, countdown rate.
- DIV (localparam) = CLK_HZ / TICK_HZ, integer floor. Must be ≥ 4; elaborate-time assertion.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cpu_we  in  1  CPU write strobe, single cycle, never stalled.
- cpu_sel  in  1  CPU target: 0 = delay, 1 = sound.
- cpu_wdata  in  8  CPU write value.
- host_we  in  1  host write request; held high until host_ack.
- host_sel  in  1  host target: 0 = delay, 1 = sound.
- host_wdata  in  8  host write value; stable while host_we is high.
- host_ack  out  1  one-cycle pulse; host write has been applied.
- pause  in  1  freezes the tick divider; writes still accepted.
- delay_value  out  8  delay register.
- sound_value  out  8  sound register.
- sound_on  out  1  (sound_value != 0), combinational from the register.
- tick_out  out  1  registered one-cycle tick pulse, for debug and CPU use.

## Operation
- Divider counts 0..DIV-1 while pause = 0 and holds while pause = 1. The internal strobe tick is asserted when count == DIV-1 and pause = 0; the count then wraps to 0.
- Sequencer FSM states and transitions:
  - IDLE: on tick, go to DEC_D.
  - DEC_D: delay ← delay − 1 if delay != 0; go to DEC_S.
  - DEC_S: sound ← sound − 1 if sound != 0; go to IDLE.
  - Both decrements use one shared decrementer, muxed by state.
  - A zero register stays 0. No wrap to 0xFF.
- Write arbitration per target register, per cycle:
  - cpu_we wins over host_we for the same target. The host request stays pending with no ack.
  - Different targets: both writes apply in the same cycle and host_ack pulses.
  - Any write to a register wins over that register's decrement in the same cycle. That register skips its decrement for this tick.
- host_ack is never asserted unless the write was applied. A new host request may start the cycle after host_ack.
- Reset, including mid-sequence: both registers = 0, FSM = IDLE, divider = 0, host_ack = 0, tick_out = 0. A pending host request is dropped; the host re-asserts after reset.

## Timing
- Write at cycle t: value visible on *_value at t+1; host_ack high at t+1.
- tick strobe at cycle T:
  - tick_out = 1 at T+1.
  - FSM in DEC_D at T+1; delay_value updated at T+2.
  - FSM in DEC_S at T+2; sound_value updated at T+3.
  - FSM back in IDLE at T+3.
- Because DIV ≥ 4, a tick never arrives while the FSM is busy.
- sound_on follows sound_value with zero added latency. It drops in the same cycle sound_value reaches 0.
- Tick period is exactly DIV unpaused cycles. Cycles spent in pause do not count.

## Structure
- Package chip8_timer_pkg contains:
  - typedef enum logic {SEL_DELAY = 1'b0, SEL_SOUND = 1'b1} timer_sel_e
  - typedef enum logic [1:0] {S_IDLE, S_DEC_D, S_DEC_S} tseq_state_e
  - localparam TIMER_W = 8
- Sub-module chip8_tick_gen holds the divider, the pause handling, and the tick strobe output. Ports: clk, reset, pause, tick.
- The FSM, the shared decrementer and the arbitration stay in chip8_timer_ctrl.

## Test plan
All scenarios use CLK_HZ = 240, TICK_HZ = 60, so DIV = 4.
1. Countdown:
   - Stimulus: CPU writes delay = 3 and sound = 2, then idle.
   - Required: delay steps 3→2→1→0 on consecutive ticks; sound steps 2→1→0, each update one cycle after delay's.
   - Required: sound_on falls with sound_value = 0; both registers stay 0 on later ticks.
2. Same-target collision:
   - Stimulus: cpu_we (sel 0, 0x10) and host_we (sel 0, 0x20) in the same cycle.
   - Required: delay = 0x10 next cycle; no host_ack.
   - Required: next cycle, delay = 0x20 and host_ack pulses once.
3. Different targets:
   - Stimulus: CPU writes delay = 5 while host writes sound = 7 in the same cycle.
   - Required: both values visible at t+1; host_ack at t+1.
4. Write vs decrement:
   - Stimulus: delay = 9; CPU writes delay = 0x40 in the DEC_D cycle.
   - Required: delay = 0x40 (not 8); sound still decrements that tick.
5. Pause:
   - Stimulus: assert pause for 10 cycles mid-period.
   - Required: tick_out spacing is 4 + 10 cycles; register values unchanged during pause; writes during pause apply.
6. Reset:
   - Stimulus: reset in the DEC_D cycle with delay = 3, sound = 3 and a host request pending.
   - Required: all outputs 0 the next cycle; FSM IDLE; no host_ack; first tick_out 4 cycles after reset deasserts.
